// File: rtl/npc_ctrl_fsm_if.sv
// Memory-port handshake bundle between the NPC sequencing controller and the IFU/LSU.
// master = controller side, slave = memory side.
interface npc_ctrl_fsm_if;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_inst;
    logic        io_dmem_req_valid;
    logic        io_dmem_req_ready;
    logic        io_dmem_resp_valid;

    modport master (
        output io_imem_req_valid,
        output io_dmem_req_valid,
        input  io_imem_req_ready,
        input  io_imem_resp_valid,
        input  io_imem_resp_inst,
        input  io_dmem_req_ready,
        input  io_dmem_resp_valid
    );

    modport slave (
        input  io_imem_req_valid,
        input  io_dmem_req_valid,
        output io_imem_req_ready,
        output io_imem_resp_valid,
        output io_imem_resp_inst,
        output io_dmem_req_ready,
        output io_dmem_resp_valid
    );
endinterface

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for the NPC core.
// Optional performance counters are built when NPC_PERF_CNT_EN is defined.
module npc_ctrl_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset_n,
    npc_ctrl_fsm_if.master mem,
    output logic [31:0]    io_inst,
    input  logic           io_dec_mem_read,
    input  logic           io_dec_mem_write,
    input  logic           io_dec_reg_write,
    input  logic           io_dec_ebreak,
    input  logic           io_dec_illegal,
    output logic           io_pc_update,
    output logic           io_rf_wen,
    output logic           io_halt,
    output logic [1:0]     io_halt_code,
    output logic [63:0]    io_cycle_cnt,
    output logic [63:0]    io_instret_cnt
);
    // state    | meaning
    // S_RESET  | held in reset, leaves on first edge after release
    // S_FETCH  | imem request raised until accepted
    // S_IWAIT  | waiting for fetch data, timeout armed
    // S_DECODE | decoder outputs sampled and latched
    // S_EXEC   | single execute cycle
    // S_MEM    | dmem request raised until accepted
    // S_MWAIT  | waiting for load data / store ack, timeout armed
    // S_WB     | pc update and register-file write strobe
    // S_HALT   | absorbing until reset, cause in io_halt_code
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_IWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic [1:0]  halt_code, halt_code_nxt;
    logic        is_mem_q, reg_write_q, mem_write_q;
    logic        ir_load, dec_latch;
    logic        imem_req_valid, dmem_req_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RESET;
            ir          <= '0;
            tmo_cnt     <= '0;
            halt_code   <= '0;
            is_mem_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            halt_code <= halt_code_nxt;
            if (ir_load) begin
                ir <= mem.io_imem_resp_inst;
            end
            if (dec_latch) begin
                is_mem_q    <= io_dec_mem_read | io_dec_mem_write;
                reg_write_q <= io_dec_reg_write;
                mem_write_q <= io_dec_mem_write;
            end
        end
    end

    // Wait counter is zero outside the wait states, so it is clear on every entry.
    always_comb begin
        state_nxt      = state;
        tmo_cnt_nxt    = '0;
        halt_code_nxt  = halt_code;
        ir_load        = 1'b0;
        dec_latch      = 1'b0;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        io_pc_update   = 1'b0;
        io_rf_wen      = 1'b0;
        io_halt        = 1'b0;
        unique case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (mem.io_imem_req_ready) state_nxt = S_IWAIT;
            end
            S_IWAIT: begin
                if (mem.io_imem_resp_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt     = S_HALT;
                    halt_code_nxt = 2'd3;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                dec_latch = 1'b1;
                if (io_dec_illegal || (io_dec_mem_read && io_dec_mem_write)) begin
                    state_nxt     = S_HALT;
                    halt_code_nxt = 2'd2;
                end else if (io_dec_ebreak) begin
                    state_nxt     = S_HALT;
                    halt_code_nxt = 2'd1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: state_nxt = is_mem_q ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req_valid = 1'b1;
                if (mem.io_dmem_req_ready) state_nxt = S_MWAIT;
            end
            S_MWAIT: begin
                if (mem.io_dmem_resp_valid) begin
                    state_nxt = S_WB;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt     = S_HALT;
                    halt_code_nxt = 2'd3;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            S_WB: begin
                io_pc_update = 1'b1;
                io_rf_wen    = reg_write_q & ~mem_write_q;
                state_nxt    = S_FETCH;
            end
            S_HALT: io_halt = 1'b1;
            default: state_nxt = S_RESET;
        endcase
    end

    assign mem.io_imem_req_valid = imem_req_valid;
    assign mem.io_dmem_req_valid = dmem_req_valid;
    assign io_inst               = ir;
    assign io_halt_code          = halt_code;

`ifdef NPC_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_RESET && state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
            if (state == S_WB) instret_cnt <= instret_cnt + 64'd1;
        end
    end

    assign io_cycle_cnt   = cycle_cnt;
    assign io_instret_cnt = instret_cnt;
`else
    assign io_cycle_cnt   = '0;
    assign io_instret_cnt = '0;
`endif
endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Scoreboard bench for npc_ctrl_fsm: directed instructions push expected retire/halt events,
// a negedge monitor pops and compares them when pc_update or halt appears.
module tb_npc_ctrl_fsm;
    localparam logic [31:0] I_ADDI   = 32'h00100093;
    localparam logic [31:0] I_LW     = 32'h0000a103;
    localparam logic [31:0] I_SD     = 32'h00b13023;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
`ifdef NPC_PERF_CNT_EN
    localparam logic [63:0] PERF_MASK = '1;
`else
    localparam logic [63:0] PERF_MASK = '0;
`endif

    typedef struct {
        bit          is_halt;
        logic [1:0]  code;
        logic        rf_wen;
        logic [31:0] inst;
        int          at_cyc;
        logic [63:0] cyc_cnt;
        logic [63:0] instret;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] io_inst;
    logic        io_dec_mem_read, io_dec_mem_write, io_dec_reg_write, io_dec_ebreak, io_dec_illegal;
    logic        io_pc_update, io_rf_wen, io_halt;
    logic [1:0]  io_halt_code;
    logic [63:0] io_cycle_cnt, io_instret_cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pc_n = 0;
    int   dreq_n = 0;
    bit   halt_seen = 0;
    exp_t exp_q[$];

    logic [31:0] cur_inst = '0;
    int i_rdy_dly = 0, i_resp_dly = 0, d_rdy_dly = 0, d_resp_dly = 0;
    bit i_never = 0, d_never = 0, force_both = 0;

    always #5 clock = ~clock;

    npc_ctrl_fsm_if mif ();

    npc_ctrl_fsm #(.TIMEOUT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .mem              (mif),
        .io_inst          (io_inst),
        .io_dec_mem_read  (io_dec_mem_read),
        .io_dec_mem_write (io_dec_mem_write),
        .io_dec_reg_write (io_dec_reg_write),
        .io_dec_ebreak    (io_dec_ebreak),
        .io_dec_illegal   (io_dec_illegal),
        .io_pc_update     (io_pc_update),
        .io_rf_wen        (io_rf_wen),
        .io_halt          (io_halt),
        .io_halt_code     (io_halt_code),
        .io_cycle_cnt     (io_cycle_cnt),
        .io_instret_cnt   (io_instret_cnt)
    );

    // Minimal RV64 decoder model feeding the controller.
    always_comb begin
        io_dec_mem_read  = 1'b0;
        io_dec_mem_write = 1'b0;
        io_dec_reg_write = 1'b0;
        io_dec_ebreak    = 1'b0;
        io_dec_illegal   = 1'b0;
        case (io_inst[6:0])
            7'h03: begin io_dec_mem_read = 1'b1; io_dec_reg_write = 1'b1; end
            7'h23: io_dec_mem_write = 1'b1;
            7'h13, 7'h33: io_dec_reg_write = 1'b1;
            7'h73: if (io_inst == I_EBREAK) io_dec_ebreak = 1'b1; else io_dec_illegal = 1'b1;
            default: io_dec_illegal = 1'b1;
        endcase
        if (force_both) begin
            io_dec_mem_read  = 1'b1;
            io_dec_mem_write = 1'b1;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not match expectation (t=%0t)", name, $time);
    endfunction

    // Instruction memory: ready after i_rdy_dly stalled cycles, data after i_resp_dly wait cycles.
    initial begin : imem_model
        int ph, cnt;
        ph = 0; cnt = 0;
        mif.io_imem_req_ready = 1'b0; mif.io_imem_resp_valid = 1'b0; mif.io_imem_resp_inst = '0;
        forever begin
            @(negedge clock);
            mif.io_imem_req_ready = 1'b0; mif.io_imem_resp_valid = 1'b0;
            if (!reset_n) ph = 0;
            else case (ph)
                0: if (mif.io_imem_req_valid) begin
                       cnt = 0;
                       if (i_rdy_dly == 0) begin mif.io_imem_req_ready = 1'b1; ph = 2; end
                       else begin cnt = 1; ph = 1; end
                   end
                1: if (cnt == i_rdy_dly) begin mif.io_imem_req_ready = 1'b1; ph = 2; cnt = 0; end
                   else cnt++;
                2: if (!i_never) begin
                       if (cnt == i_resp_dly) begin
                           mif.io_imem_resp_valid = 1'b1; mif.io_imem_resp_inst = cur_inst; ph = 0;
                       end else cnt++;
                   end
                default: ph = 0;
            endcase
        end
    end

    initial begin : dmem_model
        int ph, cnt;
        ph = 0; cnt = 0;
        mif.io_dmem_req_ready = 1'b0; mif.io_dmem_resp_valid = 1'b0;
        forever begin
            @(negedge clock);
            mif.io_dmem_req_ready = 1'b0; mif.io_dmem_resp_valid = 1'b0;
            if (!reset_n) ph = 0;
            else case (ph)
                0: if (mif.io_dmem_req_valid) begin
                       cnt = 0;
                       if (d_rdy_dly == 0) begin mif.io_dmem_req_ready = 1'b1; ph = 2; end
                       else begin cnt = 1; ph = 1; end
                   end
                1: if (cnt == d_rdy_dly) begin mif.io_dmem_req_ready = 1'b1; ph = 2; cnt = 0; end
                   else cnt++;
                2: if (!d_never) begin
                       if (cnt == d_resp_dly) begin mif.io_dmem_resp_valid = 1'b1; ph = 0; end
                       else cnt++;
                   end
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset_n) begin
            halt_seen = 0; pc_n = 0; dreq_n = 0;
        end else begin
            if (mif.io_dmem_req_valid) dreq_n++;
            if (io_pc_update) begin
                pc_n++;
                if (exp_q.size() == 0) note_fail("unexpected_retire");
                else begin
                    e = exp_q.pop_front();
                    chk("retire_kind", 64'(io_halt), 64'(e.is_halt));
                    chk("retire_cycle", 64'(cyc), 64'(e.at_cyc));
                    chk("retire_rf_wen", 64'(io_rf_wen), 64'(e.rf_wen));
                    chk("retire_inst", 64'(io_inst), 64'(e.inst));
                    chk("retire_cycle_cnt", io_cycle_cnt, e.cyc_cnt);
                    chk("retire_instret", io_instret_cnt, e.instret);
                end
            end
            if (io_halt && !halt_seen) begin
                halt_seen = 1;
                if (exp_q.size() == 0) note_fail("unexpected_halt");
                else begin
                    e = exp_q.pop_front();
                    chk("halt_kind", 64'(io_halt), 64'(e.is_halt));
                    chk("halt_cycle", 64'(cyc), 64'(e.at_cyc));
                    chk("halt_code", 64'(io_halt_code), 64'(e.code));
                    chk("halt_inst", 64'(io_inst), 64'(e.inst));
                    chk("halt_cycle_cnt", io_cycle_cnt, e.cyc_cnt);
                    chk("halt_pc_update", 64'(io_pc_update), 64'(0));
                end
            end
        end
    end

    task automatic push_exp(input bit h, input logic [1:0] code, input logic rf,
                            input logic [31:0] inst, input int at, input int ret);
        exp_t e;
        e.is_halt = h; e.code = code; e.rf_wen = rf; e.inst = inst; e.at_cyc = at;
        e.cyc_cnt = 64'(at - 1) & PERF_MASK;
        e.instret = 64'(ret) & PERF_MASK;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, 64'(mif.io_imem_req_valid), 64'(0));
        chk({tag, "_dmem_req"}, 64'(mif.io_dmem_req_valid), 64'(0));
        chk({tag, "_inst"}, 64'(io_inst), 64'(0));
        chk({tag, "_pc_update"}, 64'(io_pc_update), 64'(0));
        chk({tag, "_rf_wen"}, 64'(io_rf_wen), 64'(0));
        chk({tag, "_halt"}, 64'(io_halt), 64'(0));
        chk({tag, "_halt_code"}, 64'(io_halt_code), 64'(0));
        chk({tag, "_cycle_cnt"}, io_cycle_cnt, 64'(0));
        chk({tag, "_instret"}, io_instret_cnt, 64'(0));
    endtask

    // Reset with async check, then restore a zero-wait memory configuration.
    task automatic apply_reset();
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(posedge clock);
        exp_q.delete();
        i_rdy_dly = 0; i_resp_dly = 0; d_rdy_dly = 0; d_resp_dly = 0;
        i_never = 0; d_never = 0; force_both = 0;
    endtask

    task automatic release_reset();
        @(posedge clock); #2;
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            note_fail({name, "_timeout"});
            exp_q.delete();
        end
    endtask

    task automatic wait_neg(input int c);
        int n = 0;
        @(negedge clock);
        while (cyc != c && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (cyc != c) note_fail("wait_cycle_timeout");
    endtask

    initial begin
        apply_reset();

        // back-to-back addi, zero-wait
        cur_inst = I_ADDI;
        push_exp(0, 2'd0, 1'b1, I_ADDI, 5, 0);
        push_exp(0, 2'd0, 1'b1, I_ADDI, 10, 1);
        release_reset();
        wait_neg(6);
        chk("addi_cycle_cnt", io_cycle_cnt, 64'd5 & PERF_MASK);
        chk("addi_instret", io_instret_cnt, 64'd1 & PERF_MASK);
        wait_drain("addi");
        apply_reset();

        // load, zero-wait: 7-cycle latency
        cur_inst = I_LW;
        push_exp(0, 2'd0, 1'b1, I_LW, 7, 0);
        release_reset();
        wait_drain("lw");
        apply_reset();

        // store with 3 stalled ready cycles and response on second wait cycle
        cur_inst = I_SD; d_rdy_dly = 3; d_resp_dly = 1;
        push_exp(0, 2'd0, 1'b0, I_SD, 11, 0);
        release_reset();
        wait_drain("sd");
        repeat (2) @(negedge clock);
        chk("sd_dreq_cycles", 64'(dreq_n), 64'd4);
        chk("sd_pc_updates", 64'(pc_n), 64'd1);
        apply_reset();

        // ebreak: halt code 1, counter frozen
        cur_inst = I_EBREAK;
        push_exp(1, 2'd1, 1'b0, I_EBREAK, 4, 0);
        release_reset();
        wait_drain("ebreak");
        repeat (5) @(negedge clock);
        chk("ebreak_cycle_frozen", io_cycle_cnt, 64'd3 & PERF_MASK);
        chk("ebreak_pc_updates", 64'(pc_n), 64'd0);
        chk("ebreak_halt_sticky", 64'(io_halt), 64'd1);
        chk("ebreak_inst_held", 64'(io_inst), 64'(I_EBREAK));
        chk("ebreak_no_fetch", 64'(mif.io_imem_req_valid), 64'd0);
        apply_reset();

        // all-zero encoding is illegal
        cur_inst = 32'h0;
        push_exp(1, 2'd2, 1'b0, 32'h0, 4, 0);
        release_reset();
        wait_drain("illegal");
        apply_reset();

        // decoder claims both load and store
        cur_inst = I_LW; force_both = 1;
        push_exp(1, 2'd2, 1'b0, I_LW, 4, 0);
        release_reset();
        wait_drain("rd_wr_both");
        apply_reset();

        // fetch response never arrives: halt 4 cycles after entering IWAIT
        cur_inst = I_ADDI; i_never = 1;
        push_exp(1, 2'd3, 1'b0, 32'h0, 6, 0);
        release_reset();
        wait_drain("imem_timeout");
        apply_reset();

        // response on the 4th wait cycle beats the timeout
        cur_inst = I_ADDI; i_resp_dly = 3;
        push_exp(0, 2'd0, 1'b1, I_ADDI, 8, 0);
        release_reset();
        wait_drain("imem_late_resp");
        chk("late_resp_no_halt", 64'(io_halt), 64'd0);
        apply_reset();

        // data response never arrives
        cur_inst = I_LW; d_never = 1;
        push_exp(1, 2'd3, 1'b0, I_LW, 10, 0);
        release_reset();
        wait_drain("dmem_timeout");
        apply_reset();

        // reset pulsed during MWAIT, then a clean zero-wait load
        cur_inst = I_LW; d_resp_dly = 10;
        release_reset();
        wait_neg(7);
        chk("mwait_inst_loaded", 64'(io_inst), 64'(I_LW));
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("mwait_rst");
        d_resp_dly = 0;
        push_exp(0, 2'd0, 1'b1, I_LW, 7, 0);
        @(posedge clock);
        release_reset();
        wait_neg(1);
        chk("refetch_after_rst", 64'(mif.io_imem_req_valid), 64'd1);
        wait_drain("lw_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
